sysbus_mem_provider: RTL and testbench
======================================

SYSBUS_MEM_PROVIDER -- requirements
Module: sysbus_mem_provider

Interface
REQ-001 Parameter ADDR_WIDTH, default 32, SHALL be the byte-address width of rw_addr and inv_addr.
REQ-002 Parameter DATA_WIDTH, default 64, SHALL be the width of r_data and w_data.
REQ-003 Parameter MASK_WIDTH, default DATA_WIDTH/8, SHALL be the width of w_mask, one bit per byte.
REQ-004 Parameter DEPTH_WORDS, default 1024, power of two, SHALL be the backing-store size in DATA_WIDTH words.
REQ-005 Parameter LATENCY, default 2, range 1..15, SHALL be the request-to-completion delay in cycles.
REQ-006 Parameter INV_DEPTH, default 4, power of two, SHALL be the invalidation-queue capacity.
REQ-007 clk  in  1  single clock; all state changes on the rising edge.
REQ-008 rst_n  in  1  reset, asynchronous and active-low.
REQ-009 bus  SystemBus.provider  --  the rw_valid, rw_addr, rw_we, w_ce, w_mask, w_data and inv_ready inputs; the rw_ready, r_data, inv_valid and inv_addr outputs.

Function
REQ-010 FSM states SHALL be IDLE, BUSY, WAIT_INV and RESP.
REQ-011 In IDLE with rw_valid=1: capture addr, we, ce, mask and data; load the counter with LATENCY-1; go to BUSY, or straight to RESP when LATENCY=1.
REQ-012 In BUSY: decrement the counter each cycle; at zero, go to RESP, or go to WAIT_INV if the captured access is a write with w_ce=1 and the invalidation queue is full.
REQ-013 WAIT_INV SHALL hold until the queue is not full, then go to RESP.
REQ-014 RESP SHALL last exactly one cycle with rw_ready=1, then return to IDLE; rw_ready SHALL never be high on two consecutive cycles.
REQ-015 When the queue is never full, rw_ready SHALL assert exactly LATENCY cycles after the IDLE cycle that sampled rw_valid.
REQ-016 Word index SHALL be rw_addr[log2(MASK_WIDTH) +: log2(DEPTH_WORDS)]; upper address bits are ignored, so addresses alias modulo DEPTH_WORDS.
REQ-017 Read (captured rw_we=0): r_data SHALL be registered on the transition into RESP, be valid while rw_ready=1, and hold until the next read.
REQ-018 Write (rw_we=1, w_ce=1): bytes whose w_mask bit is 1 SHALL be updated at the RESP clock edge; bytes whose mask bit is 0 are unchanged.
REQ-019 A write with w_ce=0 SHALL be acknowledged normally with no memory update and no invalidation.
REQ-020 The user SHALL hold request fields stable until rw_ready; if rw_valid drops early, the provider SHALL still complete using the captured fields.
REQ-021 Invalidation queue: FIFO of word-aligned addresses (low log2(MASK_WIDTH) bits zeroed); inv_valid = not empty; inv_addr = head entry.
REQ-022 A transfer SHALL occur when inv_valid and inv_ready are both 1 at a clock edge, popping the head.
REQ-023 Push SHALL occur in the RESP cycle of each accepted write with w_ce=1; a same-cycle push and pop SHALL both take effect with the count unchanged.
REQ-024 Duplicate addresses SHALL NOT be merged; order is strict FIFO.

Reset
REQ-025 While rst_n=0: state IDLE, counter 0, rw_ready 0, r_data 0, queue empty, inv_valid 0, inv_addr 0.
REQ-026 Reset asserted mid-request SHALL abort the request with no memory write and no queue push; memory contents are not reset.

Configuration
REQ-027 With macro SYSBUS_INV_EN defined: the invalidation queue, the WAIT_INV state and REQ-021..024 are built.
REQ-028 Without SYSBUS_INV_EN: no queue is built; inv_valid=0 and inv_addr=0 constantly; inv_ready is ignored; BUSY goes directly to RESP.

Verification
REQ-029 LATENCY=2: read addr 0x10 after preload 0x1122334455667788 -> rw_ready high exactly 2 cycles after acceptance, r_data=0x1122334455667788.
REQ-030 Write addr 0x8, w_mask=0x0F, w_data=0xFFFFFFFFAAAAAAAA onto 0 -> read-back 0x00000000AAAAAAAA; inv_addr=0x8 with inv_valid=1.
REQ-031 inv_ready=0, five writes w_ce=1 (INV_DEPTH=4) -> fifth rw_ready withheld until inv_ready=1 for one cycle; the queue then drains all five addresses in order.
REQ-032 Write with w_ce=0, mask 0xFF -> rw_ready pulse, memory unchanged, inv_valid stays 0.
REQ-033 rst_n low in BUSY of a write to 0x20 -> rw_ready 0, word 0x20 unchanged, queue empty after release.
REQ-034 DEPTH_WORDS=1024, read 0x2000 after writing 0x0 -> same data (alias); build without SYSBUS_INV_EN -> inv_valid stays 0.

Source files
------------

// File: rtl/sysbus_mem_provider.sv
// Fixed-latency word memory on a valid/ready request bus with byte-masked writes.
// Define SYSBUS_INV_EN to build the write-invalidation FIFO and its WAIT_INV back-pressure.
module sysbus_mem_provider #(
  parameter int unsigned ADDR_WIDTH  = 32,
  parameter int unsigned DATA_WIDTH  = 64,
  parameter int unsigned MASK_WIDTH  = DATA_WIDTH / 8,
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter int unsigned LATENCY     = 2,
  parameter int unsigned INV_DEPTH   = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  rw_valid,
  input  logic [ADDR_WIDTH-1:0] rw_addr,
  input  logic                  rw_we,
  input  logic                  w_ce,
  input  logic [MASK_WIDTH-1:0] w_mask,
  input  logic [DATA_WIDTH-1:0] w_data,
  output logic                  rw_ready,
  output logic [DATA_WIDTH-1:0] r_data,
  output logic                  inv_valid,
  input  logic                  inv_ready,
  output logic [ADDR_WIDTH-1:0] inv_addr
);

  localparam int unsigned OffsW = (MASK_WIDTH > 1) ? $clog2(MASK_WIDTH) : 0;
  localparam int unsigned IdxW  = $clog2(DEPTH_WORDS);
  localparam int unsigned CntW  = 4;

  typedef enum logic [1:0] {StIdle, StBusy, StWaitInv, StResp} state_e;

  state_e                  state_q;
  logic [CntW-1:0]         cnt_q;
  logic [ADDR_WIDTH-1:0]   addr_q;
  logic                    we_q;
  logic                    ce_q;
  logic [MASK_WIDTH-1:0]   mask_q;
  logic [DATA_WIDTH-1:0]   data_q;

  logic [DATA_WIDTH-1:0]   mem [DEPTH_WORDS];
  logic [IdxW-1:0]         idx;
  logic                    mem_we;
  logic                    inv_full;

  assign idx    = addr_q[OffsW +: IdxW];
  // Memory update and FIFO push share the single RESP cycle of a committed write.
  assign mem_we = (state_q == StResp) && we_q && ce_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= StIdle;
      cnt_q    <= '0;
      addr_q   <= '0;
      we_q     <= 1'b0;
      ce_q     <= 1'b0;
      mask_q   <= '0;
      data_q   <= '0;
      rw_ready <= 1'b0;
      r_data   <= '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (rw_valid) begin
            addr_q <= rw_addr;
            we_q   <= rw_we;
            ce_q   <= w_ce;
            mask_q <= w_mask;
            data_q <= w_data;
            cnt_q  <= CntW'(LATENCY - 1);
            if (LATENCY > 1) begin
              state_q <= StBusy;
            end else if (rw_we && w_ce && inv_full) begin
              // Single-cycle latency still must not push into a full FIFO.
              state_q <= StWaitInv;
            end else begin
              state_q  <= StResp;
              rw_ready <= 1'b1;
              if (!rw_we) begin
                r_data <= mem[rw_addr[OffsW +: IdxW]];
              end
            end
          end
        end
        StBusy: begin
          cnt_q <= cnt_q - 1'b1;
          if (cnt_q == CntW'(1)) begin
            if (we_q && ce_q && inv_full) begin
              state_q <= StWaitInv;
            end else begin
              state_q  <= StResp;
              rw_ready <= 1'b1;
              if (!we_q) begin
                r_data <= mem[idx];
              end
            end
          end
        end
        StWaitInv: begin
          // Only committed writes get here, so r_data is left alone.
          if (!inv_full) begin
            state_q  <= StResp;
            rw_ready <= 1'b1;
          end
        end
        StResp: begin
          state_q  <= StIdle;
          rw_ready <= 1'b0;
        end
        default: begin
          state_q  <= StIdle;
          rw_ready <= 1'b0;
        end
      endcase
    end
  end

  // Backing store is intentionally not reset.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      for (int b = 0; b < int'(MASK_WIDTH); b++) begin
        if (mask_q[b]) begin
          mem[idx][b*8 +: 8] <= data_q[b*8 +: 8];
        end
      end
    end
  end

`ifdef SYSBUS_INV_EN
  localparam int unsigned PtrW = (INV_DEPTH > 1) ? $clog2(INV_DEPTH) : 1;
  localparam logic [ADDR_WIDTH-1:0] OffsMask = ADDR_WIDTH'(MASK_WIDTH - 1);

  logic [ADDR_WIDTH-1:0] inv_mem [INV_DEPTH];
  logic [PtrW-1:0]       wr_ptr_q;
  logic [PtrW-1:0]       rd_ptr_q;
  logic [PtrW:0]         count_q;
  logic                  inv_pop;

  assign inv_full  = (count_q == (PtrW + 1)'(INV_DEPTH));
  assign inv_valid = (count_q != '0);
  assign inv_pop   = inv_valid && inv_ready;
  assign inv_addr  = inv_valid ? inv_mem[rd_ptr_q] : '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (mem_we) begin
        wr_ptr_q <= (wr_ptr_q == PtrW'(INV_DEPTH - 1)) ? '0 : wr_ptr_q + 1'b1;
      end
      if (inv_pop) begin
        rd_ptr_q <= (rd_ptr_q == PtrW'(INV_DEPTH - 1)) ? '0 : rd_ptr_q + 1'b1;
      end
      if (mem_we && !inv_pop) begin
        count_q <= count_q + 1'b1;
      end else if (!mem_we && inv_pop) begin
        count_q <= count_q - 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (mem_we) begin
      inv_mem[wr_ptr_q] <= addr_q & ~OffsMask;
    end
  end
`else
  logic unused_bits;

  assign inv_full    = 1'b0;
  assign inv_valid   = 1'b0;
  assign inv_addr    = '0;
  assign unused_bits = ^{inv_ready, addr_q};
`endif

endmodule

// File: tb/tb_sysbus_mem_provider.sv
// Scoreboard bench for sysbus_mem_provider: directed cases plus randomized traffic checked
// against a word-array reference model; adapts to builds with or without SYSBUS_INV_EN.
`timescale 1ns/1ps
module tb_sysbus_mem_provider;

  localparam int unsigned Depth = 1024;
  localparam int unsigned Lat   = 2;
`ifdef SYSBUS_INV_EN
  localparam bit InvEn = 1'b1;
`else
  localparam bit InvEn = 1'b0;
`endif

  logic        clk;
  logic        rst_n;
  logic        rw_valid;
  logic [31:0] rw_addr;
  logic        rw_we;
  logic        w_ce;
  logic [7:0]  w_mask;
  logic [63:0] w_data;
  logic        rw_ready;
  logic [63:0] r_data;
  logic        inv_valid;
  logic        inv_ready;
  logic [31:0] inv_addr;

  sysbus_mem_provider #(
    .ADDR_WIDTH (32),
    .DATA_WIDTH (64),
    .MASK_WIDTH (8),
    .DEPTH_WORDS(Depth),
    .LATENCY    (Lat),
    .INV_DEPTH  (4)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .rw_valid (rw_valid),
    .rw_addr  (rw_addr),
    .rw_we    (rw_we),
    .w_ce     (w_ce),
    .w_mask   (w_mask),
    .w_data   (w_data),
    .rw_ready (rw_ready),
    .r_data   (r_data),
    .inv_valid(inv_valid),
    .inv_ready(inv_ready),
    .inv_addr (inv_addr)
  );

  typedef struct {
    bit          is_read;
    logic [63:0] data;
    int          issue;
    bit          chk_lat;
  } exp_t;

  exp_t        exp_q[$];
  logic [31:0] inv_q[$];
  int          known_list[$];
  logic [63:0] model_mem [Depth];
  bit          known [Depth];
  int          cyc = 0;
  int          n_cmp = 0;
  int          n_err = 0;
  int          resp_cnt = 0;
  int          inv_mode = 2;  // 0 random, 1 low, 2 high, 3 one-cycle pulse
  logic [63:0] last_read = '0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
    end
  endtask

  // inv_ready driver
  initial begin
    inv_ready = 1'b0;
    forever begin
      @(posedge clk);
      #2;
      case (inv_mode)
        0: inv_ready = 1'($urandom_range(0, 1));
        1: inv_ready = 1'b0;
        2: inv_ready = 1'b1;
        default: begin
          inv_ready = 1'b1;
          inv_mode  = 1;
        end
      endcase
    end
  end

  // Monitor: pops expectations whenever the DUT presents a response or an invalidation.
  initial begin
    exp_t        e;
    logic [31:0] ea;
    bit          prev_ready;
    prev_ready = 1'b0;
    forever begin
      @(negedge clk);
      if (rw_ready === 1'b1) begin
        check("ready_single_cycle", 64'(prev_ready), 64'd0);
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_err++;
          $display("FAIL resp_spurious: rw_ready=1 with nothing outstanding, required 0");
        end else begin
          e = exp_q.pop_front();
          if (e.chk_lat) check("latency", 64'(cyc - e.issue), 64'(Lat));
          if (e.is_read) begin
            check("read_data", r_data, e.data);
            last_read = e.data;
          end else begin
            check("r_data_hold", r_data, last_read);
          end
`ifndef SYSBUS_INV_EN
          check("inv_valid_off", 64'(inv_valid), 64'd0);
          check("inv_addr_off", 64'(inv_addr), 64'd0);
`endif
        end
        resp_cnt++;
      end
      prev_ready = (rw_ready === 1'b1);
      if (inv_valid === 1'b1) begin
        if (inv_q.size() == 0) begin
          n_cmp++;
          n_err++;
          $display("FAIL inv_spurious: inv_valid=1 addr 0x%0h, required no entry", inv_addr);
        end else if (inv_ready) begin
          ea = inv_q.pop_front();
          check("inv_addr_order", 64'(inv_addr), 64'(ea));
        end
      end
    end
  end

  task automatic issue(input bit we, input bit ce, input logic [31:0] addr,
                       input logic [7:0] mask, input logic [63:0] data,
                       input bit chk, input bit track);
    exp_t e;
    int   idx;
    rw_valid = 1'b1;
    rw_we    = we;
    w_ce     = ce;
    rw_addr  = addr;
    w_mask   = mask;
    w_data   = data;
    if (track) begin
      idx       = int'((addr >> 3) % 32'(Depth));
      e.is_read = !we;
      e.data    = model_mem[idx];
      e.issue   = cyc;
      e.chk_lat = chk;
      if (we && ce) begin
        for (int b = 0; b < 8; b++) begin
          if (mask[b]) model_mem[idx][b*8 +: 8] = data[b*8 +: 8];
        end
        if (!known[idx] && mask == 8'hFF) begin
          known[idx] = 1'b1;
          known_list.push_back(idx);
        end
        if (InvEn) inv_q.push_back(addr & ~32'h7);
      end
      exp_q.push_back(e);
    end
  endtask

  task automatic wait_resp(input int start, input bit drop_early);
    int t;
    t = 0;
    if (drop_early) begin
      @(posedge clk);
      #1;
      rw_valid = 1'b0;
      rw_we    = 1'($urandom);
      w_ce     = 1'($urandom);
      rw_addr  = $urandom;
      w_mask   = 8'($urandom);
      w_data   = {$urandom, $urandom};
    end
    while (resp_cnt == start && t < 100) begin
      @(negedge clk);
      #1;
      t++;
    end
    if (resp_cnt == start) begin
      n_cmp++;
      n_err++;
      $display("FAIL resp_timeout: no rw_ready within 100 cycles, required a response");
    end
    @(posedge clk);
    #1;
    rw_valid = 1'b0;
  endtask

  task automatic do_req(input bit we, input bit ce, input logic [31:0] addr,
                        input logic [7:0] mask, input logic [63:0] data);
    int start;
    start = resp_cnt;
    issue(we, ce, addr, mask, data, !(InvEn && we && ce) || inv_mode == 2, 1'b1);
    wait_resp(start, $urandom_range(0, 3) == 0);
  endtask

  task automatic drain();
    int t;
    t = 0;
    inv_mode = 2;
    while (inv_q.size() != 0 && t < 60) begin
      @(posedge clk);
      #1;
      t++;
    end
    repeat (2) begin
      @(posedge clk);
      #1;
    end
    check("inv_drained", 64'(inv_q.size()), 64'd0);
    check("inv_valid_idle", 64'(inv_valid), 64'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int          start;
    logic [31:0] ra;
    logic [7:0]  m;
    int          idx;
    rst_n    = 1'b0;
    rw_valid = 1'b0;
    rw_addr  = '0;
    rw_we    = 1'b0;
    w_ce     = 1'b0;
    w_mask   = '0;
    w_data   = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_rw_ready", 64'(rw_ready), 64'd0);
    check("rst_r_data", r_data, 64'd0);
    check("rst_inv_valid", 64'(inv_valid), 64'd0);
    check("rst_inv_addr", 64'(inv_addr), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Preload and read back with fixed latency.
    do_req(1'b1, 1'b1, 32'h10, 8'hFF, 64'h1122_3344_5566_7788);
    do_req(1'b0, 1'b0, 32'h10, 8'h00, 64'h0);
    // Masked write onto zero.
    do_req(1'b1, 1'b1, 32'h8, 8'hFF, 64'h0);
    do_req(1'b1, 1'b1, 32'h8, 8'h0F, 64'hFFFF_FFFF_AAAA_AAAA);
    do_req(1'b0, 1'b0, 32'h8, 8'h00, 64'h0);
    drain();

    // Write with w_ce=0 is acknowledged without effect.
    do_req(1'b1, 1'b1, 32'h18, 8'hFF, 64'hDEAD_BEEF_0123_4567);
    drain();
    do_req(1'b1, 1'b0, 32'h18, 8'hFF, 64'h5555_5555_5555_5555);
    check("ce0_no_inv", 64'(inv_valid), 64'd0);
    do_req(1'b0, 1'b0, 32'h18, 8'h00, 64'h0);

    // Address aliasing modulo depth.
    do_req(1'b1, 1'b1, 32'h0, 8'hFF, 64'hCAFE_F00D_8BAD_F00D);
    do_req(1'b0, 1'b0, 32'h2000, 8'h00, 64'h0);
    drain();

    // Reset in the middle of a write aborts it.
    do_req(1'b1, 1'b1, 32'h20, 8'hFF, 64'h0F0F_0F0F_0F0F_0F0F);
    drain();
    start = resp_cnt;
    issue(1'b1, 1'b1, 32'h20, 8'hFF, 64'hFFFF_0000_FFFF_0000, 1'b0, 1'b0);
    @(posedge clk);
    #1;
    rst_n    = 1'b0;
    rw_valid = 1'b0;
    #1;
    check("abort_rw_ready", 64'(rw_ready), 64'd0);
    check("abort_r_data", r_data, 64'd0);
    check("abort_inv_valid", 64'(inv_valid), 64'd0);
    check("abort_inv_addr", 64'(inv_addr), 64'd0);
    last_read = '0;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (4) begin
      @(posedge clk);
      #1;
    end
    check("abort_no_resp", 64'(resp_cnt), 64'(start));
    check("abort_queue_empty", 64'(inv_valid), 64'd0);
    do_req(1'b0, 1'b0, 32'h20, 8'h00, 64'h0);

`ifdef SYSBUS_INV_EN
    // Full invalidation FIFO stalls the fifth committed write.
    drain();
    inv_mode = 1;
    do_req(1'b1, 1'b1, 32'h100, 8'hFF, 64'h1);
    do_req(1'b1, 1'b1, 32'h308, 8'hFF, 64'h2);
    do_req(1'b1, 1'b1, 32'h100, 8'hFF, 64'h3);
    do_req(1'b1, 1'b1, 32'h40, 8'hFF, 64'h4);
    start = resp_cnt;
    issue(1'b1, 1'b1, 32'h5C3, 8'hFF, 64'h5, 1'b0, 1'b1);
    repeat (12) begin
      @(posedge clk);
      #1;
    end
    check("inv_full_stall", 64'(resp_cnt), 64'(start));
    check("inv_full_valid", 64'(inv_valid), 64'd1);
    inv_mode = 3;
    wait_resp(start, 1'b0);
    drain();
    do_req(1'b0, 1'b0, 32'h100, 8'h00, 64'h0);
`endif

    // Randomized traffic with random invalidation back-pressure.
    inv_mode = 0;
    for (int n = 0; n < 150; n++) begin
      if (known_list.size() == 0 || $urandom_range(0, 9) < 4) begin
        ra  = $urandom;
        idx = int'((ra >> 3) % 32'(Depth));
        m   = known[idx] ? 8'($urandom) : 8'hFF;
        do_req(1'b1, $urandom_range(0, 4) != 0, ra, m, {$urandom, $urandom});
      end else begin
        idx = known_list[$urandom_range(0, known_list.size() - 1)];
        ra  = $urandom;
        ra  = (ra & 32'hFFFF_E007) | (32'(idx) << 3);
        do_req(1'b0, 1'($urandom), ra, 8'($urandom), {$urandom, $urandom});
      end
    end
    drain();
    check("resp_all_seen", 64'(exp_q.size()), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
